// File: rtl/decoder_2to4_hold_pkg.sv
// Shared definitions for the 2-to-4 hold decoder: FSM encoding and the
// one-hot decode helper.
package decoder_2to4_hold_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  function automatic logic [3:0] onehot4(input logic [1:0] y);
    return 4'b0001 << y;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/decoder_2to4_hold_if.sv
// Encoded-code handshake plus regenerated one-hot outputs of the hold decoder.
interface decoder_2to4_hold_if #(
  parameter int CNT_W = 8
);
  logic [1:0]       y;
  logic             v;
  logic             ready;
  logic [3:0]       I;
  logic             busy;
  logic [CNT_W-1:0] accept_cnt;

  modport master (
    output y, v,
    input  ready, I, busy, accept_cnt
  );

  modport slave (
    input  y, v,
    output ready, I, busy, accept_cnt
  );
endinterface

// File: rtl/decoder_2to4_hold_sat_counter.sv
// Saturating up-counter for accepted codes; sticks at all-ones.
module decoder_2to4_hold_sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/decoder_2to4_hold.sv
// Regenerates a one-hot line vector from an encoded (y, v) pair, holds it
// for HOLD_CYCLES, then forces a GAP_CYCLES dead time before the next accept.
module decoder_2to4_hold
  import decoder_2to4_hold_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 1,
  parameter int CNT_W       = 8
) (
  input logic               clk,
  input logic               rst,
  decoder_2to4_hold_if.slave bus
);

  localparam int TW = $clog2(max2(HOLD_CYCLES, GAP_CYCLES) + 1);

  state_e          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [3:0]      i_q, i_d;
  logic            accept;
  logic [CNT_W-1:0] cnt;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    i_d     = i_q;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.v) begin
          accept  = 1'b1;
          i_d     = onehot4(bus.y);
          timer_d = TW'(HOLD_CYCLES - 1);
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (timer_q == '0) begin
          i_d = '0;
          // With no dead gap the block is ready again right after the hold.
          if (GAP_CYCLES == 0) begin
            state_d = ST_IDLE;
            timer_d = '0;
          end else begin
            state_d = ST_GAP;
            timer_d = TW'(GAP_CYCLES - 1);
          end
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      ST_GAP: begin
        if (timer_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        timer_d = '0;
        i_d     = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      i_q     <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      i_q     <= i_d;
    end
  end

  decoder_2to4_hold_sat_counter #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc_i(accept),
    .cnt_o(cnt)
  );

  assign bus.ready      = (state_q == ST_IDLE);
  assign bus.busy       = (state_q == ST_HOLD) || (state_q == ST_GAP);
  assign bus.I          = i_q;
  assign bus.accept_cnt = cnt;

endmodule

// File: tb/tb_decoder_2to4_hold.sv
// Scoreboard bench for decoder_2to4_hold: a timing-level reference model
// predicts accepts, a negedge monitor checks every pulse the DUT presents.
module tb_decoder_2to4_hold;

  localparam int H       = 4;
  localparam int G       = 1;
  localparam int W       = 8;
  localparam int CNT_MAX = (1 << W) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  decoder_2to4_hold_if #(.CNT_W(W)) bus_a ();
  decoder_2to4_hold_if #(.CNT_W(2)) bus_b ();

  decoder_2to4_hold #(.HOLD_CYCLES(H), .GAP_CYCLES(G), .CNT_W(W)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a)
  );

  decoder_2to4_hold #(.HOLD_CYCLES(4), .GAP_CYCLES(0), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [3:0] onehot;
    int         cnt;
  } exp_t;

  exp_t q[$];
  exp_t m_e;
  int   m_wait     = 0;  // cycles until the block can accept again
  int   m_cnt      = 0;
  int   rst_events = 0;

  // Reference model: a code is taken whenever v is high and the previous
  // pulse plus its gap has fully elapsed.
  initial forever begin
    @(posedge clk);
    if (rst === 1'b1) begin
      m_wait = 0;
      m_cnt  = 0;
      q.delete();
      rst_events++;
    end else if (m_wait == 0 && bus_a.v === 1'b1) begin
      m_e.onehot = '0;
      m_e.onehot[int'(bus_a.y)] = 1'b1;
      m_cnt     = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
      m_e.cnt   = m_cnt;
      q.push_back(m_e);
      m_wait = H + G;
    end else if (m_wait > 0) begin
      m_wait--;
    end
  end

  logic [3:0] prev_i   = '0;
  int         hold_len = 0;
  int         seen_rst = 0;
  exp_t       got;

  initial forever begin
    @(negedge clk);
    if (rst_events > 0) begin
      if (seen_rst != rst_events) begin
        seen_rst = rst_events;
        prev_i   = '0;
        hold_len = 0;
      end
      check("ready", 32'(bus_a.ready), 32'(m_wait == 0));
      check("busy", 32'(bus_a.busy), 32'(m_wait != 0));
      check("cnt_track", 32'(bus_a.accept_cnt), m_cnt);
      check("never_multihot", 32'($countones(bus_a.I) <= 1), 1);
      if (bus_a.I != 4'b0 && prev_i == 4'b0) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: got I=%b expected no pulse at %0t", bus_a.I, $time);
        end else begin
          got = q.pop_front();
          check("pulse_I", 32'(bus_a.I), 32'(got.onehot));
          check("pulse_cnt", 32'(bus_a.accept_cnt), got.cnt);
        end
        hold_len = 1;
      end else if (bus_a.I != 4'b0) begin
        check("I_held", 32'(bus_a.I), 32'(prev_i));
        hold_len++;
      end else if (prev_i != 4'b0) begin
        check("hold_len", hold_len, H);
      end
      prev_i = bus_a.I;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [3:0] prev_b;
  int         starts, last_start;

  initial begin
    rst     = 1'b1;
    bus_a.v = 1'b0;
    bus_a.y = 2'd0;
    bus_b.v = 1'b0;
    bus_b.y = 2'd0;
    step(2);
    rst = 1'b0;
    @(negedge clk);
    check("reset_I", 32'(bus_a.I), 0);
    check("reset_busy", 32'(bus_a.busy), 0);
    check("reset_ready", 32'(bus_a.ready), 1);
    check("reset_cnt", 32'(bus_a.accept_cnt), 0);
    step(1);

    // Single code y=2
    bus_a.y = 2'd2;
    bus_a.v = 1'b1;
    step(1);
    bus_a.v = 1'b0;
    step(10);
    check("single_cnt", 32'(bus_a.accept_cnt), 1);

    // Sweep with v held high continuously
    bus_a.v = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus_a.y = 2'(k);
      step(H + G + 1);
    end
    bus_a.v = 1'b0;
    step(8);
    check("sweep_cnt", 32'(bus_a.accept_cnt), 5);

    // v low never accepts
    bus_a.y = 2'd3;
    step(10);
    check("no_accept_cnt", 32'(bus_a.accept_cnt), 5);
    check("no_accept_I", 32'(bus_a.I), 0);

    // Reset in the second HOLD cycle, with a competing accept request
    bus_a.y = 2'd1;
    bus_a.v = 1'b1;
    step(1);
    bus_a.v = 1'b0;
    step(1);
    check("hold2_I", 32'(bus_a.I), 32'(4'b0010));
    rst     = 1'b1;
    bus_a.v = 1'b1;
    bus_a.y = 2'd2;
    step(1);
    rst     = 1'b0;
    bus_a.v = 1'b0;
    @(negedge clk);
    check("rst_hold_I", 32'(bus_a.I), 0);
    check("rst_hold_ready", 32'(bus_a.ready), 1);
    check("rst_hold_cnt", 32'(bus_a.accept_cnt), 0);
    step(1);

    // Random traffic: y changes freely while busy, occasional reset
    for (int n = 0; n < 400; n++) begin
      bus_a.y = 2'($urandom_range(0, 3));
      bus_a.v = ($urandom_range(0, 3) != 0);
      rst     = ($urandom_range(0, 149) == 0);
      step(1);
    end
    rst     = 1'b0;
    bus_a.v = 1'b0;
    step(10);

    // No-gap, 2-bit counter instance
    rst = 1'b1;
    step(1);
    rst        = 1'b0;
    bus_b.v    = 1'b1;
    prev_b     = '0;
    starts     = 0;
    last_start = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      check("b_never_multihot", 32'($countones(bus_b.I) <= 1), 1);
      if (bus_b.I != 4'b0 && prev_b == 4'b0) begin
        starts++;
        if (starts > 1) check("b_spacing", c - last_start, 5);
        last_start = c;
      end
      prev_b  = bus_b.I;
      bus_b.y = 2'($urandom_range(0, 3));
    end
    check("b_starts", starts, 8);
    check("b_sat_cnt", 32'(bus_b.accept_cnt), 3);
    bus_b.v = 1'b0;
    step(2);
    check("queue_drained", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
